// File: rtl/fsm_pkg.sv
// Shared types and encodings for the OTP array sequencer.
package fsm_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PRG_SCAN,
        PRG_PULSE,
        PRG_NEXT,
        RD_SCAN,
        RD_DONE,
        HOLD
    } state_t;

    localparam logic [1:0] MODE_IDLE = 2'b00;
    localparam logic [1:0] MODE_PRG  = 2'b01;
    localparam logic [1:0] MODE_RD   = 2'b10;

    localparam logic [1:0] PL_IDLE = 2'b00;
    localparam logic [1:0] PL_PRG  = 2'b01;
    localparam logic [1:0] PL_RD   = 2'b10;

endpackage

// File: rtl/fsm.sv
// OTP array sequencer: programs or reads one column of an A x B array.
// All macro-facing outputs are registered from the next-state decode.
//
// state     | meaning
// ----------+------------------------------------------------------
// IDLE      | waiting for a program or read request
// PRG_SCAN  | looking for the next '1' bit of the latched data
// PRG_PULSE | high-voltage pulse on one cell, waiting for the ack
// PRG_NEXT  | one-cycle discharge between cells
// RD_SCAN   | sensing one row per cycle of the latched column
// RD_DONE   | publishing the assembled read word
// HOLD      | operation done, waiting for mode to change
module fsm
    import fsm_pkg::*;
#(
    parameter int A        = 2,
    parameter int B        = 2,
    parameter int MAX_WAIT = 16,
    localparam int ADDR_WIDTH = (B > 1) ? $clog2(B) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            mode,
    input  logic [ADDR_WIDTH-1:0] column,
    input  logic [A-1:0]          data_in,
    input  logic                  writing_successful,
    output logic [2*B-1:0]        PL,
    output logic [B-1:0]          BL,
    output logic [A-1:0]          WLN,
    output logic [A-1:0]          WLP,
    output logic                  PRG,
    output logic                  read_active,
    output logic [A-1:0]          data_out
);

    localparam int RW = (A > 1) ? $clog2(A) : 1;
    localparam int WW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
    localparam logic [RW-1:0]         ROW_LAST  = RW'(A - 1);
    localparam logic [WW-1:0]         WAIT_LAST = WW'(MAX_WAIT - 1);
    localparam logic [ADDR_WIDTH:0]   COL_LIM   = (ADDR_WIDTH + 1)'(B);

    state_t                 state, state_d;
    logic [RW-1:0]          row, row_d;
    logic [WW-1:0]          wcnt, wcnt_d;
    logic [ADDR_WIDTH-1:0]  col_q, col_d;
    logic [A-1:0]           din_q, din_d;
    logic [1:0]             op_q, op_d;
    logic [A-1:0]           data_q, data_q_d;
    logic [A-1:0]           data_out_d;
    logic [A-1:0][B-1:0]    shadow, shadow_d;

    logic [2*B-1:0]         pl_d;
    logic [B-1:0]           bl_d;
    logic [A-1:0]           wln_d, wlp_d;
    logic                   prg_d, ra_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_d;
    end

    always_comb begin
        state_d    = state;
        row_d      = row;
        wcnt_d     = wcnt;
        col_d      = col_q;
        din_d      = din_q;
        op_d       = op_q;
        data_q_d   = data_q;
        data_out_d = data_out;
        shadow_d   = shadow;
        case (state)
            IDLE: begin
                if (mode == MODE_PRG || mode == MODE_RD) begin
                    col_d = column;
                    din_d = data_in;
                    op_d  = mode;
                    row_d = '0;
                    if ({1'b0, column} >= COL_LIM) state_d = HOLD;
                    else if (mode == MODE_PRG)     state_d = PRG_SCAN;
                    else                           state_d = RD_SCAN;
                end
            end
            PRG_SCAN: begin
                if (din_q[row]) begin
                    state_d = PRG_PULSE;
                    wcnt_d  = '0;
                end else if (row == ROW_LAST) begin
                    state_d = HOLD;
                end else begin
                    row_d = row + 1'b1;
                end
            end
            PRG_PULSE: begin
                if (writing_successful) begin
                    shadow_d[row][col_q] = 1'b1;
                    state_d = PRG_NEXT;
                end else if (wcnt == WAIT_LAST) begin
                    // cell left unprogrammed; host sees it on the next read
                    state_d = PRG_NEXT;
                end else begin
                    wcnt_d = wcnt + 1'b1;
                end
            end
            PRG_NEXT: begin
                if (row == ROW_LAST) begin
                    state_d = HOLD;
                end else begin
                    row_d   = row + 1'b1;
                    state_d = PRG_SCAN;
                end
            end
            RD_SCAN: begin
                data_q_d[row] = shadow[row][col_q];
                if (row == ROW_LAST) state_d = RD_DONE;
                else                 row_d   = row + 1'b1;
            end
            RD_DONE: begin
                data_out_d = data_q;
                state_d    = HOLD;
            end
            HOLD: begin
                if (mode != op_q) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Decode from the next state so the lines change on the edge entering it.
    always_comb begin
        pl_d  = '0;
        bl_d  = '0;
        wln_d = '0;
        wlp_d = '0;
        prg_d = 1'b0;
        ra_d  = 1'b0;
        case (state_d)
            PRG_PULSE: begin
                prg_d                         = 1'b1;
                wlp_d[row_d]                  = 1'b1;
                bl_d[col_d]                   = 1'b1;
                pl_d[2*int'(col_d) +: 2]      = PL_PRG;
            end
            RD_SCAN: begin
                ra_d                          = 1'b1;
                wln_d[row_d]                  = 1'b1;
                bl_d[col_d]                   = 1'b1;
                pl_d[2*int'(col_d) +: 2]      = PL_RD;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            row         <= '0;
            wcnt        <= '0;
            col_q       <= '0;
            din_q       <= '0;
            op_q        <= MODE_IDLE;
            data_q      <= '0;
            data_out    <= '0;
            shadow      <= '0;
            PL          <= '0;
            BL          <= '0;
            WLN         <= '0;
            WLP         <= '0;
            PRG         <= 1'b0;
            read_active <= 1'b0;
        end else begin
            row         <= row_d;
            wcnt        <= wcnt_d;
            col_q       <= col_d;
            din_q       <= din_d;
            op_q        <= op_d;
            data_q      <= data_q_d;
            data_out    <= data_out_d;
            shadow      <= shadow_d;
            PL          <= pl_d;
            BL          <= bl_d;
            WLN         <= wln_d;
            WLP         <= wlp_d;
            PRG         <= prg_d;
            read_active <= ra_d;
        end
    end

endmodule

// File: tb/tb_fsm.sv
// Directed bench for the OTP sequencer with A=2, B=2, MAX_WAIT=16.
// Output vector layout: {PRG, read_active, WLP, WLN, BL, PL}.
module tb_fsm;

    logic       clk;
    logic       reset;
    logic [1:0] mode;
    logic [0:0] column;
    logic [1:0] data_in;
    logic       writing_successful;
    logic [3:0] PL;
    logic [1:0] BL;
    logic [1:0] WLN;
    logic [1:0] WLP;
    logic       PRG;
    logic       read_active;
    logic [1:0] data_out;

    int checks = 0;
    int errors = 0;

    logic [11:0] obs;
    assign obs = {PRG, read_active, WLP, WLN, BL, PL};

    localparam logic [11:0] ZERO = 12'h000;

    fsm #(.A(2), .B(2), .MAX_WAIT(16)) dut (
        .clk                (clk),
        .reset              (reset),
        .mode               (mode),
        .column             (column),
        .data_in            (data_in),
        .writing_successful (writing_successful),
        .PL                 (PL),
        .BL                 (BL),
        .WLN                (WLN),
        .WLP                (WLP),
        .PRG                (PRG),
        .read_active        (read_active),
        .data_out           (data_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [11:0] ov(input logic prg, input logic ra, input logic [1:0] wlp,
                                       input logic [1:0] wln, input logic [1:0] bl, input logic [3:0] pl);
        return {prg, ra, wlp, wln, bl, pl};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [11:0] got, input logic [11:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic check_dout(input string tag, input logic [1:0] exp);
        check(tag, {10'b0, data_out}, {10'b0, exp});
    endtask

    // Pulse already entered; ack arrives in the pulse's third cycle.
    task automatic pulse3(input string tag, input logic [11:0] exp);
        check({tag, "_c1"}, obs, exp);
        tick();
        check({tag, "_c2"}, obs, exp);
        tick();
        check({tag, "_c3"}, obs, exp);
        writing_successful = 1'b1;
        tick();
        check({tag, "_discharge"}, obs, ZERO);
        writing_successful = 1'b0;
    endtask

    task automatic do_read(input string tag, input logic c, input logic [1:0] prev, input logic [1:0] exp);
        logic [1:0] bl;
        logic [3:0] pl;
        bl = 2'b01 << c;
        pl = 4'b0010 << (2 * c);
        mode   = 2'b10;
        column = c;
        tick();
        check({tag, "_row0"}, obs, ov(1'b0, 1'b1, 2'b00, 2'b01, bl, pl));
        column = ~c;
        tick();
        check({tag, "_row1"}, obs, ov(1'b0, 1'b1, 2'b00, 2'b10, bl, pl));
        tick();
        check({tag, "_done_lines"}, obs, ZERO);
        check_dout({tag, "_done_old"}, prev);
        tick();
        check_dout({tag, "_data"}, exp);
        mode   = 2'b00;
        column = c;
        tick();
        check({tag, "_idle"}, obs, ZERO);
    endtask

    initial begin
        reset              = 1'b0;
        mode               = 2'b00;
        column             = 1'b0;
        data_in            = 2'b00;
        writing_successful = 1'b0;

        // 1: reset and quiet idle, including the reserved mode
        repeat (5) begin
            tick();
            check("reset_lines", obs, ZERO);
        end
        check_dout("reset_dout", 2'b00);
        reset = 1'b1;
        repeat (20) begin
            tick();
            check("idle_lines", obs, ZERO);
        end
        mode = 2'b11;
        repeat (4) begin
            tick();
            check("mode11_idle", obs, ZERO);
        end
        mode = 2'b00;
        tick();

        // 2: program column 1 with 2'b11
        mode = 2'b01; column = 1'b1; data_in = 2'b11;
        tick();
        check("p1_scan0", obs, ZERO);
        tick();
        pulse3("p1_row0", ov(1'b1, 1'b0, 2'b01, 2'b00, 2'b10, 4'b0100));
        tick();
        check("p1_scan1", obs, ZERO);
        tick();
        pulse3("p1_row1", ov(1'b1, 1'b0, 2'b10, 2'b00, 2'b10, 4'b0100));
        tick();
        check("p1_hold", obs, ZERO);
        repeat (3) begin
            tick();
            check("p1_runs_once", obs, ZERO);
        end
        mode = 2'b00;
        tick();

        // 3: read column 1
        do_read("r1_col1", 1'b1, 2'b00, 2'b11);

        // 4: read column 0, program row 1 only, read back
        do_read("r2_col0", 1'b0, 2'b11, 2'b00);
        mode = 2'b01; column = 1'b0; data_in = 2'b10;
        tick();
        check("p2_scan0", obs, ZERO);
        tick();
        check("p2_skip0", obs, ZERO);
        tick();
        pulse3("p2_row1", ov(1'b1, 1'b0, 2'b10, 2'b00, 2'b01, 4'b0001));
        tick();
        check("p2_hold", obs, ZERO);
        mode = 2'b00;
        tick();
        do_read("r3_col0", 1'b0, 2'b00, 2'b10);

        // 5: no ack -> 16-cycle pulse then silent skip
        mode = 2'b01; column = 1'b0; data_in = 2'b01;
        tick();
        check("p3_scan0", obs, ZERO);
        tick();
        check("p3_wait_0", obs, ov(1'b1, 1'b0, 2'b01, 2'b00, 2'b01, 4'b0001));
        for (int i = 1; i < 16; i++) begin
            tick();
            check($sformatf("p3_wait_%0d", i), obs, ov(1'b1, 1'b0, 2'b01, 2'b00, 2'b01, 4'b0001));
        end
        tick();
        check("p3_timeout", obs, ZERO);
        tick();
        check("p3_scan1", obs, ZERO);
        tick();
        check("p3_hold", obs, ZERO);
        mode = 2'b00;
        tick();
        do_read("r4_col0", 1'b0, 2'b10, 2'b10);
        do_read("r5_col1", 1'b1, 2'b10, 2'b11);

        // 6: asynchronous abort mid-pulse
        mode = 2'b01; column = 1'b1; data_in = 2'b11;
        tick();
        tick();
        check("p4_pulse", obs, ov(1'b1, 1'b0, 2'b01, 2'b00, 2'b10, 4'b0100));
        #3;
        reset = 1'b0;
        #1;
        check("abort_lines", obs, ZERO);
        check_dout("abort_dout", 2'b00);
        mode = 2'b00;
        tick();
        tick();
        reset = 1'b1;
        tick();
        check("post_reset_idle", obs, ZERO);
        do_read("r6_col1", 1'b1, 2'b00, 2'b00);
        do_read("r7_col0", 1'b0, 2'b00, 2'b00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
